// File: rtl/dma_pcis_rd_framer_pkg.sv
// Shared types for the DMA PCIS read framer: queued AR command record, framer
// state encoding and the fixed R response code.
package dma_pcis_rd_framer_pkg;

  localparam int CMD_ID_W  = 6;
  localparam int CMD_LEN_W = 8;

  // Default-width command record; the top builds its own from its parameters.
  typedef struct packed {
    logic [CMD_ID_W-1:0]  id;
    logic [CMD_LEN_W-1:0] len;
  } rd_cmd_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/dma_pcis_rd_framer_cmd_fifo.sv
// Small synchronous command FIFO with registered full/empty flags; a push and a
// pop may happen in the same cycle.
module rd_cmd_fifo
  import dma_pcis_rd_framer_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = rd_cmd_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty,
  output logic full_next
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic [AW:0]    count_next;
  logic           do_push;
  logic           do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + (AW+1)'(1);
    end else if (!do_push && do_pop) begin
      count_next = count - (AW+1)'(1);
    end
  end

  // full_next lets the owner register a ready flag that tracks occupancy exactly.
  assign full_next = (count_next == (AW+1)'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= full_next;
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/dma_pcis_rd_framer.sv
// Frames the width converter's 512-bit stream into AXI4 R bursts, one burst per
// queued AR command, with the command's ID and a correctly placed rlast.
module dma_pcis_rd_framer
  import dma_pcis_rd_framer_pkg::*;
#(
  parameter int DATA_W   = 512,
  parameter int ID_W     = CMD_ID_W,
  parameter int ADDR_W   = 64,
  parameter int LEN_W    = CMD_LEN_W,
  parameter int AR_DEPTH = 4,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   s_axi_arid,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [LEN_W-1:0]  s_axi_arlen,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [ID_W-1:0]   s_axi_rid,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [CNT_W-1:0]  bursts_done,
  output logic              busy
);

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [LEN_W-1:0] len;
  } cmd_t;

  localparam logic [0:0] ST_IDLE  = IDLE;
  localparam logic [0:0] ST_BURST = BURST;

  logic [0:0]       state;
  logic [ID_W-1:0]  cur_id;
  logic [LEN_W-1:0] beats_left;
  logic [CNT_W-1:0] burst_cnt;
  logic             ar_ready_q;
  cmd_t             push_cmd;
  cmd_t             head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_full_next;
  logic             push;
  logic             pop;
  logic             in_burst;
  logic             beat;
  logic             last_beat;
  logic             unused_araddr;

  // Data is delivered in stream order, so the address carries no information.
  assign unused_araddr = ^s_axi_araddr;

  assign in_burst  = (state == ST_BURST);
  assign beat      = in_burst & s_axis_tvalid & s_axi_rready;
  assign last_beat = beat & (beats_left == '0);
  assign push      = s_axi_arvalid & ar_ready_q & ~fifo_full;
  assign pop       = ~fifo_empty & (~in_burst | last_beat);
  assign push_cmd  = '{id: s_axi_arid, len: s_axi_arlen};

  rd_cmd_fifo #(
    .DEPTH (AR_DEPTH),
    .T     (cmd_t)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .din       (push_cmd),
    .pop       (pop),
    .dout      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .full_next (fifo_full_next)
  );

  // A pop on the last beat reloads the next command so bursts run back to back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cur_id     <= '0;
      beats_left <= '0;
      burst_cnt  <= '0;
      ar_ready_q <= 1'b0;
    end else begin
      ar_ready_q <= ~fifo_full_next;
      if (pop) begin
        cur_id     <= head.id;
        beats_left <= head.len;
      end else if (beat && !last_beat) begin
        beats_left <= beats_left - LEN_W'(1);
      end
      if (last_beat) burst_cnt <= burst_cnt + CNT_W'(1);
      if (pop) begin
        state <= ST_BURST;
      end else if (last_beat) begin
        state <= ST_IDLE;
      end
    end
  end

  assign s_axi_arready = ar_ready_q;
  assign s_axi_rid     = cur_id;
  assign s_axi_rdata   = s_axis_tdata;
  assign s_axi_rresp   = RESP_OKAY;
  assign s_axi_rlast   = in_burst & (beats_left == '0);
  assign s_axi_rvalid  = in_burst & s_axis_tvalid;
  assign s_axis_tready = in_burst & s_axi_rready;
  assign bursts_done   = burst_cnt;
  assign busy          = in_burst | ~fifo_empty;

endmodule

// File: tb/tb_dma_pcis_rd_framer.sv
// Self-checking bench for dma_pcis_rd_framer: cycle-exact vector tables, directed
// corner sequences and a randomized run scored by a transaction-level model.
module tb_dma_pcis_rd_framer;

  logic         clk;
  logic         rst;
  logic [5:0]   s_axi_arid;
  logic [63:0]  s_axi_araddr;
  logic [7:0]   s_axi_arlen;
  logic         s_axi_arvalid;
  logic         s_axi_arready;
  logic [5:0]   s_axi_rid;
  logic [511:0] s_axi_rdata;
  logic [1:0]   s_axi_rresp;
  logic         s_axi_rlast;
  logic         s_axi_rvalid;
  logic         s_axi_rready;
  logic [511:0] s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [31:0]  bursts_done;
  logic         busy;

  dma_pcis_rd_framer dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_arid    (s_axi_arid),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rid     (s_axi_rid),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rlast   (s_axi_rlast),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .bursts_done   (bursts_done),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         arvalid;
    logic [5:0]   arid;
    logic [7:0]   arlen;
    logic         tvalid;
    logic [511:0] tdata;
    logic         rready;
    logic         e_arready;
    logic         e_rvalid;
    logic         e_tready;
    logic [5:0]   e_rid;
    logic         e_rlast;
    logic [511:0] e_rdata;
    logic [31:0]  e_bursts;
    logic         e_busy;
  } vec_t;

  typedef struct {
    logic [5:0] id;
    logic [7:0] len;
  } cmd_s;

  int errors = 0;
  int checks = 0;

  vec_t         tbl[$];
  cmd_s         cmd_q[$];
  logic [511:0] data_q[$];
  bit           m_active = 0;
  cmd_s         m_cur;
  int           m_beat = 0;
  logic [31:0]  m_bursts = '0;
  bit           prev_stall = 0;
  logic [5:0]   prev_rid;
  logic         prev_rlast;
  logic [511:0] prev_rdata;
  bit           stream_en = 0;
  int           tv_pct = 100;
  bit           rr_rand = 0;
  int           rr_pct = 100;
  bit           exp_idle_r = 0;
  bit           last_ar_acc = 0;
  int unsigned  word_seq = 0;
  int           bp_pat[10] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
  int           wait_n;

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkVec(input logic av, input logic [5:0] id, input logic [7:0] len,
                                 input logic tv, input logic [511:0] td, input logic rr,
                                 input logic ear, input logic erv, input logic etr,
                                 input logic [5:0] erid, input logic erl, input logic [511:0] erd,
                                 input logic [31:0] eb, input logic ebusy);
    vec_t v;
    v.arvalid = av;  v.arid = id;     v.arlen = len;
    v.tvalid = tv;   v.tdata = td;    v.rready = rr;
    v.e_arready = ear; v.e_rvalid = erv; v.e_tready = etr;
    v.e_rid = erid;  v.e_rlast = erl; v.e_rdata = erd;
    v.e_bursts = eb; v.e_busy = ebusy;
    return v;
  endfunction

  // Inputs change #1 after posedge; outputs are compared on the following negedge.
  task automatic applyStimulus(input vec_t v, input int idx);
    s_axi_arvalid = v.arvalid;
    s_axi_arid    = v.arid;
    s_axi_arlen   = v.arlen;
    s_axis_tvalid = v.tvalid;
    s_axis_tdata  = v.tdata;
    s_axi_rready  = v.rready;
    @(negedge clk);
    checkOutput($sformatf("v%0d_arready", idx), 512'(s_axi_arready), 512'(v.e_arready));
    checkOutput($sformatf("v%0d_rvalid", idx), 512'(s_axi_rvalid), 512'(v.e_rvalid));
    checkOutput($sformatf("v%0d_tready", idx), 512'(s_axis_tready), 512'(v.e_tready));
    checkOutput($sformatf("v%0d_bursts", idx), 512'(bursts_done), 512'(v.e_bursts));
    checkOutput($sformatf("v%0d_busy", idx), 512'(busy), 512'(v.e_busy));
    if (v.e_rvalid) begin
      checkOutput($sformatf("v%0d_rid", idx), 512'(s_axi_rid), 512'(v.e_rid));
      checkOutput($sformatf("v%0d_rlast", idx), 512'(s_axi_rlast), 512'(v.e_rlast));
      checkOutput($sformatf("v%0d_rdata", idx), s_axi_rdata, v.e_rdata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic offerWord();
    logic [511:0] w;
    for (int k = 0; k < 16; k++) w[k*32 +: 32] = $urandom;
    w[31:0] = word_seq;
    word_seq++;
    s_axis_tdata  = w;
    s_axis_tvalid = 1'b1;
    data_q.push_back(w);
  endtask

  task automatic stopStream();
    if (s_axis_tvalid) begin
      s_axis_tvalid = 1'b0;
      void'(data_q.pop_back());
    end
    stream_en = 0;
  endtask

  function automatic bit modelIdle();
    return !m_active && (cmd_q.size() == 0);
  endfunction

  // Transaction-level reference: each accepted AR owns the next len+1 stream words.
  task automatic monitor();
    checkOutput("rresp", 512'(s_axi_rresp), 512'(0));
    checkOutput("bursts_done", 512'(bursts_done), 512'(m_bursts));
    if (exp_idle_r) checkOutput("starve_rvalid", 512'(s_axi_rvalid), 512'(0));
    if (prev_stall) begin
      checkOutput("stall_rvalid", 512'(s_axi_rvalid), 512'(1));
      checkOutput("stall_rid", 512'(s_axi_rid), 512'(prev_rid));
      checkOutput("stall_rlast", 512'(s_axi_rlast), 512'(prev_rlast));
      checkOutput("stall_rdata", s_axi_rdata, prev_rdata);
    end
    if (s_axi_rvalid) checkOutput("tready_mirror", 512'(s_axis_tready), 512'(s_axi_rready));
    if (s_axi_rvalid && s_axi_rready) begin
      if (!m_active) begin
        checkOutput("beat_has_cmd", 512'(cmd_q.size() != 0), 512'(1));
        if (cmd_q.size() != 0) begin
          m_cur    = cmd_q.pop_front();
          m_active = 1;
          m_beat   = 0;
        end
      end
      if (m_active) begin
        checkOutput("rid", 512'(s_axi_rid), 512'(m_cur.id));
        checkOutput("rlast", 512'(s_axi_rlast), 512'(m_beat == int'(m_cur.len)));
        checkOutput("beat_has_data", 512'(data_q.size() != 0), 512'(1));
        if (data_q.size() != 0) checkOutput("rdata", s_axi_rdata, data_q.pop_front());
        if (m_beat == int'(m_cur.len)) begin
          m_active = 0;
          m_bursts = m_bursts + 32'd1;
        end else begin
          m_beat++;
        end
      end
    end
    if (s_axi_arvalid && s_axi_arready) cmd_q.push_back('{s_axi_arid, s_axi_arlen});
    prev_stall = s_axi_rvalid && !s_axi_rready;
    prev_rid   = s_axi_rid;
    prev_rlast = s_axi_rlast;
    prev_rdata = s_axi_rdata;
  endtask

  task automatic tick();
    bit s_hs;
    bit ar_hs;
    @(negedge clk);
    monitor();
    s_hs  = s_axis_tvalid && s_axis_tready;
    ar_hs = s_axi_arvalid && s_axi_arready;
    @(posedge clk);
    #1;
    last_ar_acc = ar_hs;
    if (ar_hs) s_axi_arvalid = 1'b0;
    if (stream_en) begin
      if (s_hs) s_axis_tvalid = 1'b0;
      if (!s_axis_tvalid && ($urandom_range(99) < tv_pct)) offerWord();
    end
    if (rr_rand) s_axi_rready = ($urandom_range(99) < rr_pct);
  endtask

  task automatic sendAr(input logic [5:0] id, input logic [7:0] len, input string name);
    s_axi_arvalid = 1'b1;
    s_axi_arid    = id;
    s_axi_arlen   = len;
    tick();
    checkOutput(name, 512'(last_ar_acc), 512'(1));
  endtask

  task automatic drain(input string name, input int bound);
    int n = 0;
    while (!(modelIdle() && !s_axi_arvalid) && n < bound) begin
      tick();
      n++;
    end
    checkOutput({name, "_drained"}, 512'(modelIdle()), 512'(1));
    checkOutput({name, "_busy"}, 512'(busy), 512'(0));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    s_axi_arid = '0; s_axi_araddr = 64'h1000; s_axi_arlen = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0;

    @(negedge clk);
    checkOutput("rst_arready", 512'(s_axi_arready), 512'(0));
    checkOutput("rst_rvalid", 512'(s_axi_rvalid), 512'(0));
    checkOutput("rst_tready", 512'(s_axis_tready), 512'(0));
    checkOutput("rst_rid", 512'(s_axi_rid), 512'(0));
    checkOutput("rst_rlast", 512'(s_axi_rlast), 512'(0));
    checkOutput("rst_bursts", 512'(bursts_done), 512'(0));
    checkOutput("rst_busy", 512'(busy), 512'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single request id=5 len=3, then back-to-back id=1 len=1 / id=2 len=0.
    tbl.push_back(mkVec(0, 0, 0, 0, 512'h0,  0, 0, 0, 0, 0, 0, 512'h0,  0, 0));
    tbl.push_back(mkVec(1, 5, 3, 0, 512'h0,  1, 1, 0, 0, 0, 0, 512'h0,  0, 0));
    tbl.push_back(mkVec(0, 0, 0, 1, 512'hA0, 1, 1, 0, 0, 0, 0, 512'h0,  0, 1));
    tbl.push_back(mkVec(0, 0, 0, 1, 512'hA0, 1, 1, 1, 1, 5, 0, 512'hA0, 0, 1));
    tbl.push_back(mkVec(0, 0, 0, 1, 512'hA1, 1, 1, 1, 1, 5, 0, 512'hA1, 0, 1));
    tbl.push_back(mkVec(0, 0, 0, 1, 512'hA2, 1, 1, 1, 1, 5, 0, 512'hA2, 0, 1));
    tbl.push_back(mkVec(0, 0, 0, 1, 512'hA3, 1, 1, 1, 1, 5, 1, 512'hA3, 0, 1));
    tbl.push_back(mkVec(0, 0, 0, 0, 512'h0,  1, 1, 0, 0, 0, 0, 512'h0,  1, 0));
    tbl.push_back(mkVec(1, 1, 1, 0, 512'h0,  1, 1, 0, 0, 0, 0, 512'h0,  1, 0));
    tbl.push_back(mkVec(1, 2, 0, 1, 512'hB0, 1, 1, 0, 0, 0, 0, 512'h0,  1, 1));
    tbl.push_back(mkVec(0, 0, 0, 1, 512'hB0, 1, 1, 1, 1, 1, 0, 512'hB0, 1, 1));
    tbl.push_back(mkVec(0, 0, 0, 1, 512'hB1, 1, 1, 1, 1, 1, 1, 512'hB1, 1, 1));
    tbl.push_back(mkVec(0, 0, 0, 1, 512'hB2, 1, 1, 1, 1, 2, 1, 512'hB2, 2, 1));
    tbl.push_back(mkVec(0, 0, 0, 0, 512'h0,  1, 1, 0, 0, 0, 0, 512'h0,  3, 0));
    for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i], i);
    s_axi_arvalid = 1'b0; s_axis_tvalid = 1'b0; s_axi_rready = 1'b0;
    m_bursts = 32'd3;

    // FIFO full: one command in flight plus four queued, R stalled.
    stream_en = 1; tv_pct = 100; rr_rand = 0;
    offerWord();
    for (int i = 0; i < 5; i++) sendAr(6'(10 + i), 8'd0, $sformatf("full_ar%0d_accept", i));
    s_axi_arvalid = 1'b1; s_axi_arid = 6'd15; s_axi_arlen = 8'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("full_ar5_blocked", 512'(last_ar_acc), 512'(0));
    end
    s_axi_rready = 1'b1;
    tick();
    checkOutput("full_ar5_blocked_on_last_beat", 512'(last_ar_acc), 512'(0));
    tick();
    checkOutput("full_ar5_accept_after_pop", 512'(last_ar_acc), 512'(1));
    drain("full", 60);

    // Back-pressure mid-burst.
    sendAr(6'd4, 8'd5, "bp_accept");
    for (int i = 0; i < 10; i++) begin
      s_axi_rready = bp_pat[i][0];
      tick();
    end
    s_axi_rready = 1'b1;
    drain("bp", 40);

    // Stream starvation.
    stopStream();
    sendAr(6'd3, 8'd7, "starve_accept");
    exp_idle_r = 1;
    repeat (10) tick();
    exp_idle_r = 0;
    stream_en = 1;
    offerWord();
    drain("starve", 40);

    // Maximum length burst.
    sendAr(6'd42, 8'd255, "len255_accept");
    drain("len255", 300);

    // Reset during beat 3 of a len=7 burst with two commands queued.
    sendAr(6'd6, 8'd7, "rstmid_ar0");
    sendAr(6'd7, 8'd1, "rstmid_ar1");
    sendAr(6'd8, 8'd1, "rstmid_ar2");
    wait_n = 0;
    while (!(m_active && m_beat == 2) && wait_n < 20) begin
      tick();
      wait_n++;
    end
    checkOutput("rstmid_two_beats", 512'(m_active && m_beat == 2), 512'(1));
    rst = 1'b1;
    #2;
    checkOutput("rstmid_arready", 512'(s_axi_arready), 512'(0));
    checkOutput("rstmid_rvalid", 512'(s_axi_rvalid), 512'(0));
    checkOutput("rstmid_tready", 512'(s_axis_tready), 512'(0));
    checkOutput("rstmid_rid", 512'(s_axi_rid), 512'(0));
    checkOutput("rstmid_rlast", 512'(s_axi_rlast), 512'(0));
    checkOutput("rstmid_bursts", 512'(bursts_done), 512'(0));
    checkOutput("rstmid_busy", 512'(busy), 512'(0));
    stopStream();
    cmd_q.delete(); data_q.delete();
    m_active = 0; m_bursts = '0; prev_stall = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    checkOutput("rstrel_arready", 512'(s_axi_arready), 512'(1));
    checkOutput("rstrel_busy", 512'(busy), 512'(0));
    checkOutput("rstrel_bursts", 512'(bursts_done), 512'(0));
    s_axi_rready = 1'b1;
    exp_idle_r = 1;
    repeat (3) tick();
    exp_idle_r = 0;
    checkOutput("rstrel_still_idle", 512'(busy), 512'(0));

    // Randomized traffic with random stream gaps and R back-pressure.
    stream_en = 1; tv_pct = 70; rr_rand = 1; rr_pct = 70;
    for (int c = 0; c < 400; c++) begin
      if (!s_axi_arvalid && ($urandom_range(99) < 25)) begin
        s_axi_arvalid = 1'b1;
        s_axi_arid    = 6'($urandom);
        s_axi_arlen   = 8'($urandom_range(7));
      end
      tick();
    end
    wait_n = 0;
    while (s_axi_arvalid && wait_n < 100) begin
      tick();
      wait_n++;
    end
    rr_rand = 0; s_axi_rready = 1'b1; tv_pct = 100;
    drain("random", 400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
